// File: rtl/serial_fir_seq.sv
// Sequencer for the time-multiplexed serial FIR.
// Zero-fills the circular delay line after reset, writes each accepted sample,
// then walks one shared MAC through the active taps and flags the result.
// Every output is a register loaded from the next-state decode, so the
// outputs always describe the state being entered.
module serial_fir_seq #(
   parameter int NTAPS   = 5,
   parameter int AW      = 3,
   parameter int MAC_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [AW-1:0] cfg_taps,
   input  logic          clr_ovr,
   output logic          in_ready,
   output logic          wr_en,
   output logic          wr_zero,
   output logic [AW-1:0] wr_addr,
   output logic [AW-1:0] rd_addr,
   output logic [AW-1:0] c_addr,
   output logic          mac_clr,
   output logic          mac_en,
   output logic          out_valid,
   output logic          overrun
);

   localparam logic [2:0] S_CLEAR = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_MAC   = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // Tap counter is one bit wider than an address so it can hold NTAPS itself.
   localparam int KW = AW + 1;
   localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   localparam logic [KW-1:0] NTAPS_K  = KW'(NTAPS);
   localparam logic [KW-1:0] K_ONE    = KW'(1);
   localparam logic [AW-1:0] A_LAST   = AW'(NTAPS - 1);
   localparam logic [AW-1:0] A_ONE    = AW'(1);
   localparam logic [LW-1:0] LAT_LAST = LW'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
   localparam logic [LW-1:0] L_ONE    = LW'(1);

   // Address of the sample k taps older than the newest one, wrapping modulo NTAPS.
   function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] p, input logic [KW-1:0] k);
      logic [KW:0] sum_v;
      sum_v = {2'b00, p} + {1'b0, NTAPS_K} - {1'b0, k};
      if (sum_v >= {1'b0, NTAPS_K}) begin
         sum_v = sum_v - {1'b0, NTAPS_K};
      end else begin
         sum_v = sum_v;
      end
      return sum_v[AW-1:0];
   endfunction

   // Circular pointer advance, modulo NTAPS.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (p == A_LAST) begin
         return {AW{1'b0}};
      end else begin
         return p + A_ONE;
      end
   endfunction

   // Out-of-range tap counts (0 or above NTAPS) fall back to the full filter.
   function automatic logic [KW-1:0] eff_taps(input logic [AW-1:0] cfg);
      logic [KW-1:0] c_v;
      c_v = {1'b0, cfg};
      if ((c_v == {KW{1'b0}}) || (c_v > NTAPS_K)) begin
         return NTAPS_K;
      end else begin
         return c_v;
      end
   endfunction

   logic [2:0]    state_r, state_s;
   logic [AW-1:0] ptr_r, ptr_s;
   logic [KW-1:0] k_r, k_s;
   logic [KW-1:0] ktaps_r, ktaps_s;
   logic [LW-1:0] lat_r, lat_s;
   logic          in_ready_r, in_ready_s;
   logic          wr_en_r, wr_en_s;
   logic          wr_zero_r, wr_zero_s;
   logic [AW-1:0] wr_addr_r, wr_addr_s;
   logic [AW-1:0] rd_addr_r, rd_addr_s;
   logic [AW-1:0] c_addr_r, c_addr_s;
   logic          mac_clr_r, mac_clr_s;
   logic          mac_en_r, mac_en_s;
   logic          out_valid_r, out_valid_s;
   logic          ovr_r, ovr_s;

   // Next-state and next-output decode; k_r always holds the next tap to issue.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      k_s         = k_r;
      ktaps_s     = ktaps_r;
      lat_s       = lat_r;
      in_ready_s  = 1'b0;
      wr_en_s     = 1'b0;
      wr_zero_s   = 1'b0;
      wr_addr_s   = wr_addr_r;
      rd_addr_s   = rd_addr_r;
      c_addr_s    = c_addr_r;
      mac_clr_s   = 1'b0;
      mac_en_s    = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         S_CLEAR: begin
            if (k_r < NTAPS_K) begin
               wr_en_s   = 1'b1;
               wr_zero_s = 1'b1;
               wr_addr_s = k_r[AW-1:0];
               k_s       = k_r + K_ONE;
            end else begin
               state_s    = S_IDLE;
               k_s        = {KW{1'b0}};
               in_ready_s = 1'b1;
            end
         end
         S_IDLE: begin
            if (in_valid) begin
               state_s   = S_WRITE;
               ktaps_s   = eff_taps(cfg_taps);
               k_s       = {KW{1'b0}};
               wr_en_s   = 1'b1;
               wr_addr_s = ptr_r;
               mac_clr_s = 1'b1;
            end else begin
               in_ready_s = 1'b1;
            end
         end
         S_WRITE: begin
            state_s   = S_MAC;
            mac_en_s  = 1'b1;
            c_addr_s  = k_r[AW-1:0];
            rd_addr_s = tap_addr(ptr_r, k_r);
            k_s       = k_r + K_ONE;
         end
         S_MAC: begin
            if (k_r < ktaps_r) begin
               mac_en_s  = 1'b1;
               c_addr_s  = k_r[AW-1:0];
               rd_addr_s = tap_addr(ptr_r, k_r);
               k_s       = k_r + K_ONE;
            end else if (MAC_LAT > 0) begin
               state_s = S_DRAIN;
               lat_s   = {LW{1'b0}};
            end else begin
               state_s     = S_DONE;
               out_valid_s = 1'b1;
            end
         end
         S_DRAIN: begin
            if (lat_r == LAT_LAST) begin
               state_s     = S_DONE;
               out_valid_s = 1'b1;
            end else begin
               lat_s = lat_r + L_ONE;
            end
         end
         S_DONE: begin
            state_s    = S_IDLE;
            in_ready_s = 1'b1;
            ptr_s      = ptr_inc(ptr_r);
         end
         default: begin
            state_s = S_CLEAR;
            k_s     = {KW{1'b0}};
         end
      endcase
   end

   // Sticky overrun: a strobe while not ready sets it, and setting beats clearing.
   always_comb begin
      if (in_valid && !in_ready_r) begin
         ovr_s = 1'b1;
      end else if (clr_ovr) begin
         ovr_s = 1'b0;
      end else begin
         ovr_s = ovr_r;
      end
   end

   // State and output registers; reset aborts any sample in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= S_CLEAR;
         ptr_r       <= {AW{1'b0}};
         k_r         <= {KW{1'b0}};
         ktaps_r     <= {KW{1'b0}};
         lat_r       <= {LW{1'b0}};
         in_ready_r  <= 1'b0;
         wr_en_r     <= 1'b0;
         wr_zero_r   <= 1'b0;
         wr_addr_r   <= {AW{1'b0}};
         rd_addr_r   <= {AW{1'b0}};
         c_addr_r    <= {AW{1'b0}};
         mac_clr_r   <= 1'b0;
         mac_en_r    <= 1'b0;
         out_valid_r <= 1'b0;
         ovr_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         k_r         <= k_s;
         ktaps_r     <= ktaps_s;
         lat_r       <= lat_s;
         in_ready_r  <= in_ready_s;
         wr_en_r     <= wr_en_s;
         wr_zero_r   <= wr_zero_s;
         wr_addr_r   <= wr_addr_s;
         rd_addr_r   <= rd_addr_s;
         c_addr_r    <= c_addr_s;
         mac_clr_r   <= mac_clr_s;
         mac_en_r    <= mac_en_s;
         out_valid_r <= out_valid_s;
         ovr_r       <= ovr_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign wr_en     = wr_en_r;
   assign wr_zero   = wr_zero_r;
   assign wr_addr   = wr_addr_r;
   assign rd_addr   = rd_addr_r;
   assign c_addr    = c_addr_r;
   assign mac_clr   = mac_clr_r;
   assign mac_en    = mac_en_r;
   assign out_valid = out_valid_r;
   assign overrun   = ovr_r;

endmodule

// File: tb/tb_serial_fir_seq.sv
// Bench for serial_fir_seq: a behavioural delay-line memory and single-stage
// MAC are driven by the sequencer's addresses; a monitor compares every
// write, tap step and result against expectations queued by the driver.
module tb_serial_fir_seq;

   localparam int NTAPS   = 5;
   localparam int AW      = 3;
   localparam int MAC_LAT = 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [AW-1:0] cfg_taps;
   logic          clr_ovr;
   logic          in_ready;
   logic          wr_en;
   logic          wr_zero;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] c_addr;
   logic          mac_clr;
   logic          mac_en;
   logic          out_valid;
   logic          overrun;

   serial_fir_seq #(.NTAPS(NTAPS), .AW(AW), .MAC_LAT(MAC_LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .cfg_taps(cfg_taps), .clr_ovr(clr_ovr),
      .in_ready(in_ready), .wr_en(wr_en), .wr_zero(wr_zero), .wr_addr(wr_addr),
      .rd_addr(rd_addr), .c_addr(c_addr), .mac_clr(mac_clr), .mac_en(mac_en),
      .out_valid(out_valid), .overrun(overrun)
   );

   typedef struct {
      int acc;    // edge number at which the sample is accepted
      int k;      // effective tap count
      int y;      // hand-computed filter output
      int waddr;  // delay-line slot the sample must land in
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   bit   have_cur = 1'b0;
   int   n_vec  = 0;
   int   n_miss = 0;
   int   cyc    = 0;
   int   din    = 0;

   logic signed [31:0] coef [0:7] = '{50, 20, 30, 10, 17, 0, 0, 0};
   logic signed [31:0] mem  [0:7];
   logic signed [31:0] samp_r;
   logic signed [31:0] prod_r;
   logic signed [31:0] acc_r;
   logic               prod_v_r;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter: after edge n the value is n.
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath model: sample latch, delay line, one-stage product pipeline, accumulator.
   always @(posedge clk) begin
      if (in_valid && in_ready) samp_r <= din;
      if (wr_en) mem[wr_addr] <= wr_zero ? 32'sd0 : samp_r;
      prod_v_r <= mac_en;
      prod_r   <= mem[rd_addr] * coef[c_addr];
      if (mac_clr) acc_r <= 32'sd0;
      else if (prod_v_r) acc_r <= acc_r + prod_r;
   end

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expectation at each sample write and follows it to out_valid.
   initial begin
      int mac_cnt;
      mac_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            have_cur = 1'b0;
            exp_q.delete();
         end else begin
            if (wr_en === 1'b1 && wr_zero === 1'b0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_write", wr_en, 0);
               end else begin
                  cur      = exp_q.pop_front();
                  have_cur = 1'b1;
                  mac_cnt  = 0;
                  check("wr_addr", wr_addr, cur.waddr);
                  check("mac_clr", mac_clr, 1);
                  check("write_cycle", cyc, cur.acc);
               end
            end
            if (mac_en === 1'b1) begin
               if (!have_cur) begin
                  check("unexpected_mac", mac_en, 0);
               end else begin
                  check("rd_addr", rd_addr, (cur.waddr + NTAPS - mac_cnt) % NTAPS);
                  check("c_addr", c_addr, mac_cnt);
                  mac_cnt = mac_cnt + 1;
               end
            end
            if (out_valid === 1'b1) begin
               if (!have_cur) begin
                  check("unexpected_out_valid", out_valid, 0);
               end else begin
                  // out_valid is visible in the period that ends at edge acc+K+MAC_LAT+2
                  check("out_valid_cycle", cyc, cur.acc + cur.k + MAC_LAT + 1);
                  check("mac_count", mac_cnt, cur.k);
                  check("result", acc_r, cur.y);
                  have_cur = 1'b0;
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called on a negedge; leaves the bench on the negedge gap-1 periods after acceptance.
   task automatic send(input int d, input int cfg, input int k, input int y, input int waddr, input int gap);
      exp_t e;
      logic [31:0] cfg_v;
      check("in_ready_before_accept", in_ready, 1);
      cfg_v    = cfg;
      din      = d;
      cfg_taps = cfg_v[AW-1:0];
      in_valid = 1'b1;
      e.acc    = cyc + 1;
      e.k      = k;
      e.y      = y;
      e.waddr  = waddr;
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      cfg_taps = 3'd5;
      idle(gap - 1);
   endtask

   task automatic drop(input logic with_clr);
      check("in_ready_during_busy", in_ready, 0);
      din      = 99;
      cfg_taps = 3'd1;
      in_valid = 1'b1;
      clr_ovr  = with_clr;
      @(negedge clk);
      in_valid = 1'b0;
      clr_ovr  = 1'b0;
      cfg_taps = 3'd5;
      check("overrun_set", overrun, 1);
   endtask

   task automatic pulse_clr();
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      check("overrun_cleared", overrun, 0);
   endtask

   // Follows reset release: five zero writes to slots 0..4, then ready.
   task automatic check_clear();
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         check("clear_wr_en", wr_en, ((i >= 1) && (i <= 5)) ? 1 : 0);
         check("clear_in_ready", in_ready, (i == 6) ? 1 : 0);
         if ((i >= 1) && (i <= 5)) begin
            check("clear_wr_zero", wr_zero, 1);
            check("clear_wr_addr", wr_addr, i - 1);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   int p1_din [6] = '{3, -2, 7, 1, 4, 5};
   int p1_y   [6] = '{150, -40, 400, 160, 461, 396};

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      cfg_taps = 3'd5;
      clr_ovr  = 1'b0;
      #3;
      check("reset_outputs_zero",
            {in_ready, wr_en, wr_zero, wr_addr, rd_addr, c_addr, mac_clr, mac_en, out_valid, overrun}, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      check_clear();

      // Six back-to-back samples at the minimum spacing; the sixth wraps to slot 0.
      for (int i = 0; i < 6; i++) begin
         send(p1_din[i], 5, 5, p1_y[i], i % NTAPS, 9);
      end

      // A strobe 3 periods after acceptance is dropped; result timing is unaffected.
      send(6, 5, 5, 649, 1, 3);
      drop(1'b0);
      idle(5);
      pulse_clr();
      send(2, 5, 5, 427, 2, 3);
      drop(1'b1);
      idle(5);
      pulse_clr();

      // Short filter, then an out-of-range count that falls back to all taps.
      send(8, 2, 2, 440, 3, 6);
      send(-1, 0, 5, 315, 4, 9);

      // Reset during MAC: everything drops to 0 at once and the line is re-cleared.
      send(9, 5, 5, 0, 0, 3);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midop_reset_outputs_zero",
            {in_ready, wr_en, wr_zero, wr_addr, rd_addr, c_addr, mac_clr, mac_en, out_valid, overrun}, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      check_clear();
      send(10, 5, 5, 500, 0, 9);
      send(1, 5, 5, 250, 1, 9);
      idle(10);

      check("queue_drained", exp_q.size(), 0);
      check("no_pending_result", have_cur, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
